crc_stream_check: RTL and testbench
===================================

// Module: crc_stream_check
// PURPOSE
//  Cut-through CRC-32 check-and-strip for the receive byte stream. Counterpart to the transmit-side CRC appender.
//  Takes frames of payload followed by a 4-byte CRC on the udp_rx interface and forwards the payload only on the to_udp interface.
//  Delay is 4 bytes instead of a whole-frame buffer.
//  Reports pass/fail on the final payload byte.
// PARAMETERS
//  POLY     32'h04C11DB7  CRC-32 generator (reflected, byte-serial, LSB-first)
//  INIT     32'hFFFFFFFF  CRC register value loaded on udp_rx_first
//  RESIDUE  32'hDEBB20E3  register value after payload+CRC when the frame is good
//  CNT_W    16            width of statistics counters (CRC_RX_STATS_EN only)
// PORTS
//  clk             in   1      rising-edge clock
//  rst             in   1      synchronous active-high reset
//  udp_rx          in   8      input byte
//  udp_rx_valid    in   1      byte qualifier; no backpressure
//  udp_rx_first    in   1      first byte of frame (with valid)
//  udp_rx_last     in   1      last byte of frame, i.e. CRC byte 3 (with valid)
//  to_udp          out  8      payload byte
//  to_udp_valid    out  1      payload byte qualifier
//  to_udp_first    out  1      first payload byte
//  to_udp_last     out  1      last payload byte
//  crc_check_rx    out  1      1-cycle pulse: frame verdict available
//  crc_valid_rx    out  1      verdict: 1 = residue matched; held until next udp_rx_first
//  frame_cnt       out  CNT_W  frames checked (CRC_RX_STATS_EN only)
//  err_cnt         out  CNT_W  failed or runt frames (CRC_RX_STATS_EN only)
// BEHAVIOUR
//  - Reset: all outputs 0, counters 0, delay line cleared, state IDLE.
//  - Reset asserted mid-frame discards that frame. No last is emitted for it and no verdict is given.
//  - States:
//    - IDLE: waits for valid&first.
//    - FILL: fewer than 4 bytes held.
//    - STREAM: 4 bytes held.
//  - Transitions:
//    - valid&first in any state: INIT is loaded, the byte is folded in, the delay line is reloaded with that byte, and the state goes to FILL(1).
//    - FILL→STREAM occurs when the 4th byte is accepted.
//  - Delay line: 4x8 shift register. It advances only on udp_rx_valid; gaps in valid stall the output (to_udp_valid=0).
//  - Latency: payload byte j is registered onto to_udp one cycle after input byte j+4 is accepted.
//    - No output while in FILL.
//    - to_udp_first marks output byte 0.
//  - All N input bytes (payload and CRC) are folded into the CRC register.
//  - On valid&last in STREAM:
//    - The next cycle carries to_udp_last=1 with byte N-5.
//    - crc_check_rx=1 in that same cycle.
//    - crc_valid_rx = (crc_next == RESIDUE).
//    - State goes to IDLE.
//  - Runt frame (last while in IDLE after first, or in FILL; N<5, including first&last on one byte):
//    - No payload output.
//    - The next cycle has crc_check_rx=1 and crc_valid_rx=0; state goes to IDLE.
//  - valid&first while in FILL/STREAM (truncated frame):
//    - Buffered bytes are discarded with no to_udp_last and no verdict.
//    - The new frame starts normally. The truncated frame counts as an error in stats.
//  - valid&last in IDLE with no frame open: ignored, no outputs.
//  - valid with neither flag in IDLE: ignored.
//  - crc_valid_rx clears to 0 on the next accepted udp_rx_first.
// CONFIGURATION
//  - CRC_RX_STATS_EN defined:
//    - frame_cnt increments on every crc_check_rx pulse.
//    - err_cnt increments on every crc_check_rx with crc_valid_rx=0, and on every truncated frame.
//    - Both counters wrap at 2^CNT_W.
//  - CRC_RX_STATS_EN undefined: frame_cnt/err_cnt ports are absent and no counter logic is built.
// STRUCTURE
//  - Package crc_pkg holds:
//    - CRC32_POLY, CRC32_INIT, CRC32_RESIDUE
//    - state enum {IDLE, FILL, STREAM}
//    - function crc32_byte(crc, byte): 8-step reflected update
//  - One sub-module, crc32_byte_update: purely combinational wrapper of crc32_byte, shared with the transmit appender.
//  - Top level holds the FSM, the fill counter (2 bits), the delay line, and the verdict/stat registers.
// TESTING
//  - "123456789" + CRC bytes 26 39 F4 CB (first on 31h, last on CBh):
//    - to_udp emits 31..39 with first on 31h and last on 39h.
//    - crc_check_rx and crc_valid_rx are both 1 in the to_udp_last cycle.
//  - Same frame with final byte CAh: identical payload output; crc_check_rx=1, crc_valid_rx=0.
//  - Same good frame with valid deasserted 3 cycles after byte 5:
//    - Output stalls; the same bytes are delivered in order.
//    - Verdict pass arrives 3 cycles later than the gap-free case.
//  - 4-byte frame 01 02 03 04: zero to_udp_valid cycles; crc_check_rx=1, crc_valid_rx=0.
//  - Good frame truncated by a new first after byte 6, then the good frame in full:
//    - The first frame yields no to_udp_last and no verdict.
//    - The second passes.
//    - With CRC_RX_STATS_EN: frame_cnt=1, err_cnt=1.
//  - rst pulsed while in STREAM:
//    - The next cycle shows all outputs 0.
//    - A following good frame passes with correct output.

Source files
------------

// File: rtl/crc_pkg.sv
// CRC-32 constants, checker state encoding and the reflected byte-serial CRC step
// shared by the receive checker and the transmit appender.
package crc_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam int unsigned CRC_CNT_W     = 16;

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  // LSB-first update: the generator is bit-reversed so the register shifts right.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data,
                                             input logic [31:0] poly = CRC32_POLY);
    logic [31:0] poly_rev;
    logic [31:0] c;
    for (int i = 0; i < 32; i++) poly_rev[i] = poly[31-i];
    c = crc ^ {24'h0, data};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ poly_rev) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/crc32_byte_update.sv
// Combinational one-byte CRC-32 update; latency 0, no flow control.
// Backpressure: none, pure function of its inputs.
module crc32_byte_update
  import crc_pkg::*;
#(
  parameter logic [31:0] POLY = CRC32_POLY
)(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  assign o_crc = crc32_byte(i_crc, i_data, POLY);

endmodule

// File: rtl/crc_stream_check.sv
// Cut-through CRC-32 check-and-strip: payload out one cycle after byte j+4 in, verdict with last.
// No backpressure (stalls follow udp_rx_valid gaps); CRC_RX_STATS_EN adds frame/error counters.
module crc_stream_check
  import crc_pkg::*;
#(
  parameter logic [31:0] POLY    = CRC32_POLY,
  parameter logic [31:0] INIT    = CRC32_INIT,
  parameter logic [31:0] RESIDUE = CRC32_RESIDUE
`ifdef CRC_RX_STATS_EN
  ,
  parameter int unsigned CNT_W   = CRC_CNT_W
`endif
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       udp_rx,
  input  logic             udp_rx_valid,
  input  logic             udp_rx_first,
  input  logic             udp_rx_last,
  output logic [7:0]       to_udp,
  output logic             to_udp_valid,
  output logic             to_udp_first,
  output logic             to_udp_last,
  output logic             crc_check_rx,
  output logic             crc_valid_rx
`ifdef CRC_RX_STATS_EN
  ,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_fill, w_fill_nxt;
  logic        r_first_pend, w_first_pend_nxt;
  logic [7:0]  r_dly [4];
  logic [31:0] r_crc;
  logic [31:0] w_crc_in, w_crc_nxt;
  logic        w_load, w_shift;
  logic        w_out_vld, w_out_first, w_out_last;
  logic        w_check, w_pass, w_trunc;

  // A new first restarts the CRC from INIT regardless of what was open.
  assign w_crc_in = udp_rx_first ? INIT : r_crc;

  crc32_byte_update #(.POLY(POLY)) u_crc (
    .i_crc  (w_crc_in),
    .i_data (udp_rx),
    .o_crc  (w_crc_nxt)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_fill_nxt       = r_fill;
    w_first_pend_nxt = r_first_pend;
    w_load           = 1'b0;
    w_shift          = 1'b0;
    w_out_vld        = 1'b0;
    w_out_first      = 1'b0;
    w_out_last       = 1'b0;
    w_check          = 1'b0;
    w_pass           = 1'b0;
    w_trunc          = 1'b0;
    if (udp_rx_valid) begin
      if (udp_rx_first) begin
        w_trunc          = (r_state != IDLE);
        w_load           = 1'b1;
        w_first_pend_nxt = 1'b0;
        if (udp_rx_last) begin
          w_check     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = FILL;
          w_fill_nxt  = 2'd1;
        end
      end else begin
        case (r_state)
          FILL: begin
            w_shift = 1'b1;
            if (udp_rx_last) begin
              w_check     = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_fill_nxt = r_fill + 2'd1;
              if (r_fill == 2'd3) begin
                w_state_nxt      = STREAM;
                w_first_pend_nxt = 1'b1;
              end
            end
          end
          STREAM: begin
            w_shift          = 1'b1;
            w_out_vld        = 1'b1;
            w_out_first      = r_first_pend;
            w_first_pend_nxt = 1'b0;
            if (udp_rx_last) begin
              w_out_last  = 1'b1;
              w_check     = 1'b1;
              w_pass      = (w_crc_nxt == RESIDUE);
              w_state_nxt = IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_fill       <= 2'd0;
      r_first_pend <= 1'b0;
      r_crc        <= 32'h0;
      for (int i = 0; i < 4; i++) r_dly[i] <= 8'h00;
      to_udp       <= 8'h00;
      to_udp_valid <= 1'b0;
      to_udp_first <= 1'b0;
      to_udp_last  <= 1'b0;
      crc_check_rx <= 1'b0;
      crc_valid_rx <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_fill       <= w_fill_nxt;
      r_first_pend <= w_first_pend_nxt;
      if (w_load || w_shift) r_crc <= w_crc_nxt;
      if (w_load) begin
        r_dly[0] <= udp_rx;
        r_dly[1] <= 8'h00;
        r_dly[2] <= 8'h00;
        r_dly[3] <= 8'h00;
      end else if (w_shift) begin
        r_dly[0] <= udp_rx;
        r_dly[1] <= r_dly[0];
        r_dly[2] <= r_dly[1];
        r_dly[3] <= r_dly[2];
      end
      if (w_out_vld) to_udp <= r_dly[3];
      to_udp_valid <= w_out_vld;
      to_udp_first <= w_out_first;
      to_udp_last  <= w_out_last;
      crc_check_rx <= w_check;
      // Verdict is held until the next frame opens.
      if (w_check)     crc_valid_rx <= w_pass;
      else if (w_load) crc_valid_rx <= 1'b0;
    end
  end

`ifdef CRC_RX_STATS_EN
  // A first+last byte while a frame is open is both a truncation and a runt.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (w_check) frame_cnt <= frame_cnt + CNT_W'(1);
      err_cnt <= err_cnt + CNT_W'({1'b0, w_check & ~w_pass} + {1'b0, w_trunc});
    end
  end
`endif

endmodule

// File: tb/tb_crc_stream_check.sv
// Scoreboard bench for crc_stream_check: expected bytes/verdicts queued at drive time, checked at negedge.
module tb_crc_stream_check;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] udp_rx;
  logic       udp_rx_valid, udp_rx_first, udp_rx_last;
  logic [7:0] to_udp;
  logic       to_udp_valid, to_udp_first, to_udp_last;
  logic       crc_check_rx, crc_valid_rx;
`ifdef CRC_RX_STATS_EN
  logic [15:0] frame_cnt, err_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int vrd_seen = 0;
  int last_vrd_cyc = 0;

  typedef struct {logic [7:0] d; logic f; logic l; int c;} out_t;
  typedef struct {logic pass; int c;} vrd_t;
  out_t exp_q[$];
  vrd_t vrd_q[$];

  crc_stream_check dut (
    .clk          (clk),
    .rst          (rst),
    .udp_rx       (udp_rx),
    .udp_rx_valid (udp_rx_valid),
    .udp_rx_first (udp_rx_first),
    .udp_rx_last  (udp_rx_last),
    .to_udp       (to_udp),
    .to_udp_valid (to_udp_valid),
    .to_udp_first (to_udp_first),
    .to_udp_last  (to_udp_last),
    .crc_check_rx (crc_check_rx),
    .crc_valid_rx (crc_valid_rx)
`ifdef CRC_RX_STATS_EN
    ,
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    out_t e;
    vrd_t v;
    if (to_udp_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_out", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        check("out_dat",   to_udp,       e.d);
        check("out_first", to_udp_first, e.f);
        check("out_last",  to_udp_last,  e.l);
        check("out_cyc",   cyc,          e.c);
      end
    end
    if (crc_check_rx === 1'b1) begin
      vrd_seen++;
      last_vrd_cyc = cyc;
      if (vrd_q.size() == 0) check("unexpected_verdict", vrd_q.size(), 1);
      else begin
        v = vrd_q.pop_front();
        check("verdict_pass", crc_valid_rx, v.pass);
        check("verdict_cyc",  cyc,          v.c);
      end
    end
  end

  task automatic put(input logic v, input logic [7:0] b, input logic f, input logic l, output int acc);
    @(negedge clk);
    udp_rx_valid = v;
    udp_rx       = b;
    udp_rx_first = f;
    udp_rx_last  = l;
    acc = cyc + 1;
  endtask

  task automatic idle(input int n);
    int acc;
    for (int k = 0; k < n; k++) put(1'b0, 8'h00, 1'b0, 1'b0, acc);
  endtask

  // trunc: frame ends without a last flag (cut by reset or a new first).
  task automatic send_frame(input logic [7:0] fr[$], input bit trunc, input int gap_at,
                            input int gap_len, input bit pass, output int start);
    int  n;
    int  acc;
    logic is_last;
    n = fr.size();
    start = 0;
    for (int i = 0; i < n; i++) begin
      is_last = (i == n - 1) && !trunc;
      put(1'b1, fr[i], i == 0, is_last, acc);
      if (i == 0) start = acc;
      if (i >= 4) exp_q.push_back('{fr[i-4], logic'(i == 4), is_last, acc});
      if (is_last) vrd_q.push_back('{logic'(pass), acc});
      if (i == gap_at)
        for (int k = 0; k < gap_len; k++) put(1'b0, 8'h00, 1'b0, 1'b0, acc);
    end
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_to_udp"},       to_udp,       0);
    check({pfx, "_to_udp_valid"}, to_udp_valid, 0);
    check({pfx, "_to_udp_first"}, to_udp_first, 0);
    check({pfx, "_to_udp_last"},  to_udp_last,  0);
    check({pfx, "_crc_check_rx"}, crc_check_rx, 0);
    check({pfx, "_crc_valid_rx"}, crc_valid_rx, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] good[$];
    logic [7:0] bad[$];
    logic [7:0] one[$];
    int st0, st1, acc, lat0, lat1, vs;

    good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h26, 8'h39, 8'hF4, 8'hCB};
    bad  = good;
    bad[12] = 8'hCA;
    one  = '{8'hAA};

    rst = 1'b1; udp_rx = 8'h00; udp_rx_valid = 1'b0; udp_rx_first = 1'b0; udp_rx_last = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
`ifdef CRC_RX_STATS_EN
    check("reset_frame_cnt", frame_cnt, 0);
    check("reset_err_cnt",   err_cnt,   0);
`endif
    rst = 1'b0;

    send_frame(good, 0, -1, 0, 1, st0);
    idle(3);
    lat0 = last_vrd_cyc - st0;
    check("good_valid_held", crc_valid_rx, 1);

    send_frame(bad, 0, -1, 0, 0, st1);
    idle(3);
    check("bad_valid_held", crc_valid_rx, 0);

    send_frame(good, 0, 4, 3, 1, st1);
    idle(3);
    lat1 = last_vrd_cyc - st1;
    check("gap_verdict_delay", lat1, lat0 + 3);
    check("gap_valid_held", crc_valid_rx, 1);

    // 4-byte runt: verdict clears on the first byte, then fails with no payload.
    put(1'b1, 8'h01, 1'b1, 1'b0, acc);
    put(1'b1, 8'h02, 1'b0, 1'b0, acc);
    check("valid_clr_on_first", crc_valid_rx, 0);
    put(1'b1, 8'h03, 1'b0, 1'b0, acc);
    put(1'b1, 8'h04, 1'b0, 1'b1, acc);
    vrd_q.push_back('{1'b0, acc});
    idle(3);

    send_frame(one, 0, -1, 0, 0, st1);
    idle(3);

    vs = vrd_seen;
    put(1'b1, 8'h55, 1'b0, 1'b1, acc);
    put(1'b1, 8'h66, 1'b0, 1'b0, acc);
    idle(4);
    check("stray_no_verdict", vrd_seen, vs);

    send_frame(good[0:6], 1, -1, 0, 0, st1);
    @(negedge clk);
    rst = 1'b1; udp_rx_valid = 1'b0; udp_rx_first = 1'b0; udp_rx_last = 1'b0;
    @(negedge clk);
    check_outputs_zero("midrst");
    rst = 1'b0;
    send_frame(good, 0, -1, 0, 1, st1);
    idle(3);
    check("after_rst_valid", crc_valid_rx, 1);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vs = vrd_seen;
    send_frame(good[0:5], 1, -1, 0, 0, st1);
    send_frame(good, 0, -1, 0, 1, st1);
    idle(3);
    check("trunc_verdicts", vrd_seen - vs, 1);
    check("trunc_second_pass", crc_valid_rx, 1);
`ifdef CRC_RX_STATS_EN
    check("trunc_frame_cnt", frame_cnt, 1);
    check("trunc_err_cnt",   err_cnt,   1);
`endif

    check("out_queue_drained",     exp_q.size(), 0);
    check("verdict_queue_drained", vrd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
